// File: rtl/cpu_trace_monitor.sv
// cpu_trace_monitor: snapshots CPU registers at fetch into a trace FIFO and flags jump-to-self hangs
// Ports: clk/reset (sync, active-high); en gates monitoring; cpu_state/cpu_op/rA/rB/rM/rP observed CPU;
// trace_data/trace_valid/trace_ready form the trace stream; halt/overflow sticky flags; drop_cnt/instr_cnt saturating counters.
module cpu_trace_monitor #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned STATE_W    = 3,
  parameter int unsigned FETCH_ST   = 0,
  parameter int unsigned EXEC_ST    = 2,
  parameter logic [1:0]  JMP_OP     = 2'b11,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned HANG_LIMIT = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [STATE_W-1:0]    cpu_state,
  input  logic [1:0]            cpu_op,
  input  logic [DATA_W-1:0]     rA,
  input  logic [DATA_W-1:0]     rB,
  input  logic [DATA_W-1:0]     rM,
  input  logic [DATA_W-1:0]     rP,
  output logic [4*DATA_W-1:0]   trace_data,
  output logic                  trace_valid,
  input  logic                  trace_ready,
  output logic                  halt,
  output logic                  overflow,
  output logic [7:0]            drop_cnt,
  output logic [15:0]           instr_cnt
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [4*DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]       r_wr, r_rd;
  logic [AW:0]         r_count;
  logic [7:0]          r_loop, r_drop;
  logic [15:0]         r_instr;
  logic                r_halt, r_ovf, r_valid;
  logic                w_snap, w_pop, w_push, w_drop, w_exec, w_self;
  logic [DATA_W-1:0]   w_pm1;
  logic [7:0]          w_loop_nxt;
  logic [AW:0]         w_cnt_nxt;
  always_comb begin
    w_snap     = en && !r_halt && cpu_state == STATE_W'(FETCH_ST);
    w_pop      = r_valid && trace_ready;
    // a full FIFO still accepts a push when the head leaves on the same edge
    w_push     = w_snap && (r_count != FULL || w_pop);
    w_drop     = w_snap && r_count == FULL && !w_pop;
    w_cnt_nxt  = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    w_pm1      = rP - DATA_W'(1);
    w_exec     = en && cpu_state == STATE_W'(EXEC_ST);
    w_self     = w_exec && cpu_op == JMP_OP && w_pm1 == rM;
    w_loop_nxt = w_self ? (r_loop == 8'hFF ? r_loop : r_loop + 8'd1) : w_exec ? 8'd0 : r_loop;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
      r_loop  <= '0;
      r_drop  <= '0;
      r_instr <= '0;
      r_halt  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= {rA, rB, rM, rP};
        r_wr        <= r_wr + AW'(1);
      end
      if (w_pop) r_rd <= r_rd + AW'(1);
      r_count <= w_cnt_nxt;
      r_valid <= w_cnt_nxt != '0;
      r_loop  <= w_loop_nxt;
      if (w_self && w_loop_nxt == 8'(HANG_LIMIT)) r_halt <= 1'b1;
      if (w_snap && r_instr != 16'hFFFF) r_instr <= r_instr + 16'd1;
      if (w_drop) begin
        r_ovf <= 1'b1;
        if (r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
      end
    end
  end
  assign trace_data  = r_mem[r_rd];
  assign trace_valid = r_valid;
  assign halt        = r_halt;
  assign overflow    = r_ovf;
  assign drop_cnt    = r_drop;
  assign instr_cnt   = r_instr;
endmodule

// File: doc/cpu_trace_monitor.md
CPU_TRACE_MONITOR -- requirements
Module: cpu_trace_monitor

Interface
REQ-001 SHALL have parameter DATA_W, default 8, giving the register width of rA/rB/rM/rP.
REQ-002 SHALL have parameter STATE_W, default 3, giving the width of the CPU control state.
REQ-003 SHALL have parameter FETCH_ST, default 0, naming the state in which a register snapshot is taken.
REQ-004 SHALL have parameter EXEC_ST, default 2, naming the state in which jump-to-self is checked.
REQ-005 SHALL have parameter JMP_OP, default 2'b11, giving the opcode (instr[7:6]) of the jump instruction.
REQ-006 SHALL have parameter DEPTH, default 4, a power of two >= 2, giving the trace FIFO depth.
REQ-007 SHALL have parameter HANG_LIMIT, default 1, range 1..255, giving how many consecutive self-jumps assert halt.
REQ-008 SHALL have port clk, input, 1 bit: the single clock; all logic acts on its rising edge.
REQ-009 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-010 SHALL have port en, input, 1 bit: when 1, monitoring is enabled.
REQ-011 SHALL have port cpu_state, input, STATE_W bits: the CPU control state.
REQ-012 SHALL have port cpu_op, input, 2 bits: the current instruction, instr[7:6].
REQ-013 SHALL have ports rA, rB, rM and rP, each input, DATA_W bits: the CPU registers.
REQ-014 SHALL have port trace_data, output, 4*DATA_W bits: the FIFO head, packed {rA,rB,rM,rP} with rA as the MSBs.
REQ-015 SHALL have port trace_valid, output, 1 bit: the FIFO is non-empty.
REQ-016 SHALL have port trace_ready, input, 1 bit: the consumer accepts the head.
REQ-017 SHALL have port halt, output, 1 bit: sticky flag, forever loop detected.
REQ-018 SHALL have port overflow, output, 1 bit: sticky flag, at least one snapshot has been dropped.
REQ-019 SHALL have port drop_cnt, output, 8 bits: the saturating count of dropped snapshots.
REQ-020 SHALL have port instr_cnt, output, 16 bits: the saturating count of snapshots taken, including dropped ones.

Function
REQ-021 SHALL take a snapshot on any rising edge with en=1, halt=0 and cpu_state==FETCH_ST.
REQ-022 SHALL push each snapshot {rA,rB,rM,rP}, as sampled at that edge, into the FIFO.
REQ-023 SHALL complete a handshake pop on a rising edge when trace_valid=1 and trace_ready=1.
REQ-024 SHALL drive trace_valid and trace_data from registers only; a push into an empty FIFO appears at the head one cycle after the sampling edge.
REQ-025 SHALL hold trace_data stable while trace_valid=1 and trace_ready=0.
REQ-026 SHALL drop a push made while the FIFO holds DEPTH entries and no pop occurs on the same edge, incrementing drop_cnt (saturating at 255) and setting overflow.
REQ-027 SHALL accept both operations on a simultaneous push and pop when full; occupancy stays DEPTH and nothing is dropped.
REQ-028 SHALL perform the push on a simultaneous push and pop when empty, since no pop is possible; the entry becomes valid on the next cycle.
REQ-029 SHALL use wrapping read/write pointers of log2(DEPTH) bits plus an occupancy count of log2(DEPTH)+1 bits, and SHALL keep entries in FIFO order.
REQ-030 SHALL treat an edge as a self-jump when en=1, cpu_state==EXEC_ST, cpu_op==JMP_OP and (rP - 1) mod 2^DATA_W == rM.
REQ-031 SHALL increment an 8-bit loop counter on each self-jump.
REQ-032 SHALL clear the loop counter on an EXEC_ST edge that is not a self-jump.
REQ-033 SHALL leave the loop counter unchanged on edges in other states.
REQ-034 SHALL set halt on the edge at which the loop counter reaches HANG_LIMIT.
REQ-035 SHALL keep halt set until reset, and SHALL take no further snapshots while halt=1; the FIFO still drains.
REQ-036 SHALL freeze all counters and flags while en=0; the FIFO still drains.
REQ-037 SHALL increment instr_cnt (saturating at 16'hFFFF) on every snapshot, whether accepted or dropped.

Reset
REQ-038 SHALL, on a rising edge with reset=1, empty the FIFO and clear trace_valid, trace_data, halt, overflow, drop_cnt, instr_cnt and the loop counter to 0; reset overrides all other activity on that edge.
REQ-039 SHALL discard in-flight snapshots on a reset mid-operation; the first snapshot after reset is the first one pushed.

Verification
REQ-040 SHALL show in-order delivery: DEPTH=4, trace_ready=1, three FETCH_ST cycles with rA=01,rB=02,rM=03,rP=04 then rA=11.. and rA=21.. -> trace_data 32'h01020304, then the 11.. and 21.. snapshots on consecutive cycles, each one cycle after its sample.
REQ-041 SHALL show overflow: trace_ready=0, six snapshots -> trace_valid=1, 4 entries held, drop_cnt=2, overflow=1, instr_cnt=6; then trace_ready=1 -> the first four drain in order.
REQ-042 SHALL show full with simultaneous push and pop: FIFO full, trace_ready=1 and a snapshot on one edge -> drop_cnt unchanged and the new entry at the tail.
REQ-043 SHALL show halt: HANG_LIMIT=2, EXEC_ST, cpu_op=2'b11, rM=8'h0F, rP=8'h10 for two EXEC_ST edges -> halt=1 after the second; later FETCH_ST edges leave instr_cnt unchanged.
REQ-044 SHALL show the wrap and reset cases: rP=8'h00, rM=8'hFF self-jump -> detected; an EXEC_ST non-jump between self-jumps -> no halt; reset asserted with FIFO at 3 entries -> trace_valid=0 and all counters 0 on the next cycle.
